skid_buf32: RTL

SKID_BUF32 -- requirements
Module: skid_buf32

---
 rtl/skid_pkg.sv | 13 +
 rtl/skid_buf32_reg32.sv | 33 +++
 rtl/skid_buf32.sv | 119 +++++++++++
 3 files changed

// File: rtl/skid_pkg.sv
// Shared types and constants for the skid_buf32 two-entry skid buffer.
// Optional transfer counter is enabled with SKID32_XFER_CNT_EN (see skid_buf32).
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/skid_buf32_reg32.sv
// Plain data register with load enable and asynchronous active-low clear,
// used for both the main (output) and skid storage words.
module reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/skid_buf32.sv
// Two-entry skid buffer with fully registered outputs (no input-to-output paths).
// Define SKID32_XFER_CNT_EN to add the 16-bit wrapping output-transfer counter xfer_cnt.
module skid_buf32
    import skid_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
`ifdef SKID32_XFER_CNT_EN
    output logic [XFER_CNT_W-1:0] xfer_cnt,
`endif
    output state_e                dbg_state
);

    // Handshake: a word moves on a rising edge where valid and ready are both 1
    // on the same side; valid never waits on ready, and a stalled out_data holds.
    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             main_en, skid_en, main_sel_skid;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_valid) state_d = ONE;
            ONE: begin
                if (in_valid && !out_ready)      state_d = FULL;
                else if (!in_valid && out_ready) state_d = EMPTY;
            end
            FULL:  if (out_ready) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags are computed from the next state so they can be registered.
    always_comb begin
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            EMPTY: main_en = in_valid;
            ONE: begin
                main_en = in_valid && out_ready;
                skid_en = in_valid && !out_ready;
            end
            FULL: begin
                main_en       = out_ready;
                main_sel_skid = 1'b1;
            end
            default: ;
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
        main_d      = main_sel_skid ? skid_q : in_data;
    end

    reg32 #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    reg32 #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef SKID32_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_valid_q && out_ready) begin
            xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign dbg_state = state_q;

endmodule
